// File: rtl/cla_pkg.sv
`default_nettype none
// ============================================================================
// cla_pkg: shared defaults and configuration helpers for the pipelined CLA adder
// Rev 1.0
// ============================================================================
package cla_pkg;

    localparam int DEF_WIDTH     = 16;
    localparam int DEF_CLA_WIDTH = 4;
    localparam int DEF_GPS       = 1;

    function automatic int cla_stages(input int width, input int cla_width, input int gps);
        return width / (cla_width * gps);
    endfunction

    function automatic bit cla_cfg_ok(input int width, input int cla_width, input int gps);
        return (width > 0) && (cla_width > 0) && (gps > 0) &&
               ((width % (cla_width * gps)) == 0);
    endfunction

endpackage
`default_nettype wire

// File: rtl/cla_group.sv
`default_nettype none
// ============================================================================
// cla_group: combinational CLA_WIDTH-bit carry-lookahead adder with group P/G
// Rev 1.0
// ============================================================================
module cla_group
    import cla_pkg::*;
#(
    parameter int CLA_WIDTH = DEF_CLA_WIDTH
) (
    input  logic [CLA_WIDTH-1:0] a,
    input  logic [CLA_WIDTH-1:0] b,
    input  logic                 cin,
    output logic [CLA_WIDTH-1:0] s,
    output logic                 g,
    output logic                 p,
    output logic                 cout
);

    logic [CLA_WIDTH-1:0] pb;
    logic [CLA_WIDTH-1:0] gb;
    logic [CLA_WIDTH:0]   gen;
    logic [CLA_WIDTH:0]   pall;
    logic [CLA_WIDTH:0]   c;

    assign pb = a ^ b;
    assign gb = a & b;

    // gen[i]: carry into bit i assuming cin=0; pall[i]: bits 0..i-1 all propagate
    always_comb begin
        logic term;
        term    = 1'b0;
        gen     = '0;
        pall    = '0;
        pall[0] = 1'b1;
        for (int i = 1; i <= CLA_WIDTH; i++) begin
            pall[i] = pall[i-1] & pb[i-1];
            for (int j = 0; j < i; j++) begin
                term = gb[j];
                for (int m = j + 1; m < i; m++) begin
                    term = term & pb[m];
                end
                gen[i] = gen[i] | term;
            end
        end
    end

    assign c    = gen | (pall & {(CLA_WIDTH + 1){cin}});
    assign s    = pb ^ c[CLA_WIDTH-1:0];
    assign g    = gen[CLA_WIDTH];
    assign p    = pall[CLA_WIDTH];
    assign cout = c[CLA_WIDTH];

endmodule
`default_nettype wire

// File: rtl/cla_pipelined_adder.sv
`default_nettype none
// ============================================================================
// cla_pipelined_adder: skewed, pipelined carry-lookahead adder with valid/ready
// Rev 1.0
// ============================================================================
module cla_pipelined_adder
    import cla_pkg::*;
#(
    parameter int WIDTH            = DEF_WIDTH,
    parameter int CLA_WIDTH        = DEF_CLA_WIDTH,
    parameter int GROUPS_PER_STAGE = DEF_GPS
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             overflow
);

    localparam int SW     = CLA_WIDTH * GROUPS_PER_STAGE;
    localparam int STAGES = cla_stages(WIDTH, CLA_WIDTH, GROUPS_PER_STAGE);

    if (!cla_cfg_ok(WIDTH, CLA_WIDTH, GROUPS_PER_STAGE)) begin : g_bad_cfg
        $fatal(1, "cla_pipelined_adder: WIDTH must be a multiple of CLA_WIDTH*GROUPS_PER_STAGE");
    end

    logic [STAGES-1:0] valid_q;
    logic [STAGES-1:0] carry_q;
    logic              ovf_q;
    logic [WIDTH-1:0]  sum_q [STAGES];
    logic [WIDTH-1:0]  a_q   [STAGES];
    logic [WIDTH-1:0]  b_q   [STAGES];

    logic [STAGES-1:0] vin;
    logic [STAGES-1:0] carry_d;
    logic              ovf_d;
    logic [WIDTH-1:0]  sum_d [STAGES];
    logic [WIDTH-1:0]  a_d   [STAGES];
    logic [WIDTH-1:0]  b_d   [STAGES];

    // adv[k]: stage k loads this cycle; adv[STAGES] is the consumer taking the result
    logic [STAGES:0]   adv;

    always_comb begin
        adv         = '0;
        adv[STAGES] = out_ready;
        for (int k = STAGES - 1; k >= 0; k--) begin
            adv[k] = ~valid_q[k] | adv[k+1];
        end
    end

    assign in_ready = rst_n & adv[0];

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic [WIDTH-1:0]            a_in;
        logic [WIDTH-1:0]            b_in;
        logic [WIDTH-1:0]            sum_in;
        logic                        cin_k;
        logic [SW-1:0]               sa;
        logic [SW-1:0]               sb;
        logic [SW-1:0]               ss;
        logic [GROUPS_PER_STAGE-1:0] gg;
        logic [GROUPS_PER_STAGE-1:0] gp;
        logic [GROUPS_PER_STAGE-1:0] grp_cout_unused;
        logic [GROUPS_PER_STAGE:0]   gc;

        if (k == 0) begin : g_head
            assign a_in   = a;
            assign b_in   = b;
            assign sum_in = '0;
            assign cin_k  = c_in;
            assign vin[k] = in_valid;
        end else begin : g_body
            assign a_in   = a_q[k-1];
            assign b_in   = b_q[k-1];
            assign sum_in = sum_q[k-1];
            assign cin_k  = carry_q[k-1];
            assign vin[k] = valid_q[k-1];
        end

        assign sa = a_in[k*SW +: SW];
        assign sb = b_in[k*SW +: SW];

        for (genvar j = 0; j < GROUPS_PER_STAGE; j++) begin : g_grp
            cla_group #(
                .CLA_WIDTH (CLA_WIDTH)
            ) u_grp (
                .a    (sa[j*CLA_WIDTH +: CLA_WIDTH]),
                .b    (sb[j*CLA_WIDTH +: CLA_WIDTH]),
                .cin  (gc[j]),
                .s    (ss[j*CLA_WIDTH +: CLA_WIDTH]),
                .g    (gg[j]),
                .p    (gp[j]),
                .cout (grp_cout_unused[j])
            );
        end

        // Second-level lookahead across the groups of this stage
        always_comb begin
            logic term;
            term = 1'b0;
            gc   = '0;
            for (int i = 0; i <= GROUPS_PER_STAGE; i++) begin
                term = cin_k;
                for (int j = 0; j < i; j++) begin
                    term = term & gp[j];
                end
                gc[i] = term;
                for (int j = 0; j < i; j++) begin
                    term = gg[j];
                    for (int m = j + 1; m < i; m++) begin
                        term = term & gp[m];
                    end
                    gc[i] = gc[i] | term;
                end
            end
        end

        // Sum bits above the completed slices are always zero, so OR merges the new slice
        assign carry_d[k] = gc[GROUPS_PER_STAGE];
        assign sum_d[k]   = sum_in | (WIDTH'(ss) << (k * SW));
        assign a_d[k]     = a_in;
        assign b_d[k]     = b_in;

        if (k == STAGES - 1) begin : g_tail
            assign ovf_d = (sa[SW-1] ^ sb[SW-1] ^ ss[SW-1]) ^ gc[GROUPS_PER_STAGE];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            carry_q <= '0;
            ovf_q   <= 1'b0;
            for (int k = 0; k < STAGES; k++) begin
                sum_q[k] <= '0;
                a_q[k]   <= '0;
                b_q[k]   <= '0;
            end
        end else begin
            for (int k = 0; k < STAGES; k++) begin
                if (adv[k]) begin
                    valid_q[k] <= vin[k];
                    if (vin[k]) begin
                        carry_q[k] <= carry_d[k];
                        sum_q[k]   <= sum_d[k];
                        a_q[k]     <= a_d[k];
                        b_q[k]     <= b_d[k];
                    end
                end
            end
            if (adv[STAGES-1] && vin[STAGES-1]) begin
                ovf_q <= ovf_d;
            end
        end
    end

    assign out_valid = valid_q[STAGES-1];
    assign sum       = sum_q[STAGES-1];
    assign c_out     = carry_q[STAGES-1];
    assign overflow  = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_cla_pipelined_adder.sv
`default_nettype none
// Bench for cla_pipelined_adder: directed table, pipeline corner sequences and
// randomized traffic on a 16-bit and a 32-bit (GPS=2) instance against an arithmetic model.
module tb_cla_pipelined_adder;

    localparam int W  = 16;
    localparam int W2 = 32;
    localparam int NT = 7;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n;
    logic          in_valid, in_ready, c_in, out_valid, out_ready, c_out, overflow;
    logic [W-1:0]  a, b, sum;
    logic          in_valid2, in_ready2, c_in2, out_valid2, out_ready2, c_out2, overflow2;
    logic [W2-1:0] a2, b2, sum2;

    cla_pipelined_adder #(.WIDTH(W), .CLA_WIDTH(4), .GROUPS_PER_STAGE(1)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .c_in(c_in), .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .c_out(c_out), .overflow(overflow));

    cla_pipelined_adder #(.WIDTH(W2), .CLA_WIDTH(4), .GROUPS_PER_STAGE(2)) dut32 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid2), .in_ready(in_ready2),
        .a(a2), .b(b2), .c_in(c_in2), .out_valid(out_valid2), .out_ready(out_ready2),
        .sum(sum2), .c_out(c_out2), .overflow(overflow2));

    typedef struct packed { logic ovf; logic cout; logic [31:0] sum; } exp_t;
    typedef struct { logic [15:0] a; logic [15:0] b; logic ci; logic [15:0] s; logic co; logic ov; } vec_t;

    vec_t  tbl [NT];
    exp_t  q16 [$];
    exp_t  q32 [$];
    int    out_cycles [$];
    int    n_vec = 0, n_err = 0;
    int    n_acc = 0, n_out = 0, n_out2 = 0, cyc_n = 0;
    bit    got_v, hold16, hold32, rand2_en;
    logic [W+1:0]  got16, held16;
    logic [W2+1:0] held32;

    // Reference: exact integer sum, signed overflow from the true signed result range
    function automatic exp_t ref_add(input int w, input logic [31:0] x, input logic [31:0] y, input logic ci);
        exp_t   r;
        longint full, sx, sy, ss, lim;
        lim    = longint'(1) << (w - 1);
        full   = longint'(x) + longint'(y) + longint'(ci);
        sx     = (longint'(x) >= lim) ? longint'(x) - 2 * lim : longint'(x);
        sy     = (longint'(y) >= lim) ? longint'(y) - 2 * lim : longint'(y);
        ss     = sx + sy + longint'(ci);
        r.ovf  = (ss >= lim) || (ss < -lim);
        r.cout = full[w];
        r.sum  = 32'(full);
        return r;
    endfunction

    function automatic logic [15:0] rnd16();
        case ($urandom_range(0, 7))
            0:       return 16'h0000;
            1:       return 16'hFFFF;
            2:       return 16'h8000;
            3:       return 16'h7FFF;
            default: return 16'($urandom);
        endcase
    endfunction

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    task automatic mon();
        exp_t e;
        got_v = 1'b0;
        if (!rst_n) begin
            hold16 = 1'b0;
            hold32 = 1'b0;
            return;
        end
        if (hold16) begin
            chk("hold16_valid", 64'(out_valid), 64'd1);
            chk("hold16_data", 64'({overflow, c_out, sum}), 64'(held16));
        end
        if (out_valid && out_ready) begin
            got_v = 1'b1;
            got16 = {overflow, c_out, sum};
            n_out++;
            out_cycles.push_back(cyc_n);
            if (q16.size() == 0) begin
                n_vec++; n_err++;
                $display("FAIL sb16_unexpected: got sum %0d, expected no output", sum);
            end else begin
                e = q16.pop_front();
                chk("sb16", 64'({overflow, c_out, sum}), 64'({e.ovf, e.cout, e.sum[W-1:0]}));
            end
        end
        hold16 = out_valid && !out_ready;
        held16 = {overflow, c_out, sum};
        if (in_valid && in_ready) begin
            n_acc++;
            q16.push_back(ref_add(W, 32'(a), 32'(b), c_in));
        end

        if (hold32) begin
            chk("hold32_data", 64'({out_valid2, overflow2, c_out2, sum2}), 64'({1'b1, held32}));
        end
        if (out_valid2 && out_ready2) begin
            n_out2++;
            if (q32.size() == 0) begin
                n_vec++; n_err++;
                $display("FAIL sb32_unexpected: got sum %0h, expected no output", sum2);
            end else begin
                e = q32.pop_front();
                chk("sb32", 64'({overflow2, c_out2, sum2}), 64'({e.ovf, e.cout, e.sum}));
            end
        end
        hold32 = out_valid2 && !out_ready2;
        held32 = {overflow2, c_out2, sum2};
        if (in_valid2 && in_ready2) q32.push_back(ref_add(W2, a2, b2, c_in2));
    endtask

    task automatic cyc();
        @(negedge clk);
        mon();
        @(posedge clk);
        #1;
        cyc_n++;
        if (rand2_en) begin
            in_valid2  = ($urandom_range(0, 3) != 0);
            out_ready2 = ($urandom_range(0, 3) != 0);
            a2         = ($urandom_range(0, 5) == 0) ? 32'hFFFF_FFFF : $urandom;
            b2         = ($urandom_range(0, 5) == 0) ? 32'h0000_0001 : $urandom;
            c_in2      = 1'($urandom_range(0, 1));
        end else begin
            in_valid2  = 1'b0;
            out_ready2 = 1'b1;
        end
    endtask

    initial begin
        int lat, acc0, o0;
        bit ok;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; c_in = 1'b0;
        in_valid2 = 1'b0; out_ready2 = 1'b0; a2 = '0; b2 = '0; c_in2 = 1'b0;
        rand2_en = 1'b0; hold16 = 1'b0; hold32 = 1'b0;

        tbl[0] = '{16'd12345, 16'd32914, 1'b0, 16'd45259, 1'b0, 1'b0};
        tbl[1] = '{16'd32768, 16'd32768, 1'b0, 16'd0,     1'b1, 1'b1};
        tbl[2] = '{16'd255,   16'd1111,  1'b0, 16'd1366,  1'b0, 1'b0};
        tbl[3] = '{16'd65535, 16'd0,     1'b1, 16'd0,     1'b1, 1'b0};
        tbl[4] = '{16'd32767, 16'd0,     1'b1, 16'd32768, 1'b0, 1'b1};
        tbl[5] = '{16'd65535, 16'd65535, 1'b1, 16'd65535, 1'b1, 1'b0};
        tbl[6] = '{16'd32767, 16'd32767, 1'b1, 16'd65535, 1'b0, 1'b1};

        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", 64'(in_ready), 64'd0);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_result", 64'({overflow, c_out, sum}), 64'd0);
        rst_n = 1'b1;
        #1;
        chk("release_in_ready", 64'(in_ready), 64'd1);

        // Directed vectors, one at a time, with latency check
        out_ready = 1'b1;
        for (int i = 0; i < NT; i++) begin
            a = tbl[i].a; b = tbl[i].b; c_in = tbl[i].ci; in_valid = 1'b1;
            acc0 = n_acc;
            cyc();
            in_valid = 1'b0;
            chk($sformatf("tbl%0d_accept", i), 64'(n_acc - acc0), 64'd1);
            ok = 1'b0; lat = -1;
            for (int k = 1; k <= 12 && !ok; k++) begin
                cyc();
                if (got_v) begin ok = 1'b1; lat = k - 1; end
            end
            chk($sformatf("tbl%0d_seen", i), 64'(ok), 64'd1);
            chk($sformatf("tbl%0d_result", i), 64'(got16), 64'({tbl[i].ov, tbl[i].co, tbl[i].s}));
            chk($sformatf("tbl%0d_latency", i), 64'(lat), 64'd3);
        end

        // Eight back-to-back operations must stream out on consecutive cycles
        out_cycles.delete();
        acc0 = n_acc;
        for (int i = 0; i < 8; i++) begin
            a = rnd16(); b = rnd16(); c_in = 1'($urandom_range(0, 1)); in_valid = 1'b1;
            cyc();
        end
        in_valid = 1'b0;
        for (int k = 0; k < 20 && out_cycles.size() < 8; k++) cyc();
        chk("b2b_accepts", 64'(n_acc - acc0), 64'd8);
        chk("b2b_outputs", 64'(out_cycles.size()), 64'd8);
        if (out_cycles.size() == 8) chk("b2b_span", 64'(out_cycles[7] - out_cycles[0]), 64'd7);

        // Stall with a full pipe: only four operations fit
        out_ready = 1'b0;
        acc0 = n_acc;
        for (int i = 0; i < 5; i++) begin
            a = rnd16(); b = rnd16(); c_in = 1'($urandom_range(0, 1)); in_valid = 1'b1;
            cyc();
        end
        chk("stall_accepts", 64'(n_acc - acc0), 64'd4);
        chk("stall_in_ready", 64'(in_ready), 64'd0);
        chk("stall_out_valid", 64'(out_valid), 64'd1);
        in_valid = 1'b0;
        repeat (3) cyc();
        out_ready = 1'b1;
        out_cycles.delete();
        for (int k = 0; k < 12 && out_cycles.size() < 4; k++) cyc();
        repeat (2) cyc();
        chk("drain_outputs", 64'(out_cycles.size()), 64'd4);
        chk("drain_empty", 64'(q16.size()), 64'd0);

        // Randomized traffic on both instances
        rand2_en = 1'b1;
        for (int i = 0; i < 6000; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            a = rnd16(); b = rnd16(); c_in = 1'($urandom_range(0, 1));
            cyc();
        end
        in_valid = 1'b0; out_ready = 1'b1; rand2_en = 1'b0;
        repeat (12) cyc();
        chk("rand16_empty", 64'(q16.size()), 64'd0);
        chk("rand32_empty", 64'(q32.size()), 64'd0);
        chk("rand32_active", 64'(n_out2 > 1000), 64'd1);

        // Asynchronous reset with operations in flight
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            a = rnd16(); b = rnd16(); c_in = 1'b0; in_valid = 1'b1;
            cyc();
        end
        in_valid = 1'b0;
        repeat (4) cyc();
        chk("prerst_out_valid", 64'(out_valid), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_out_valid", 64'(out_valid), 64'd0);
        chk("async_result", 64'({overflow, c_out, sum}), 64'd0);
        chk("async_in_ready", 64'(in_ready), 64'd0);
        q16.delete();
        q32.delete();
        repeat (2) cyc();
        rst_n = 1'b1;
        #1;
        chk("rerelease_in_ready", 64'(in_ready), 64'd1);
        out_ready = 1'b1;
        o0 = n_out;
        repeat (6) cyc();
        chk("no_stale_beat", 64'(n_out - o0), 64'd0);
        a = 16'd1; b = 16'd2; c_in = 1'b0; in_valid = 1'b1;
        cyc();
        in_valid = 1'b0;
        ok = 1'b0;
        for (int k = 0; k < 12 && !ok; k++) begin
            cyc();
            if (got_v) ok = 1'b1;
        end
        chk("post_rst_seen", 64'(ok), 64'd1);
        chk("post_rst_sum", 64'(got16), 64'd3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
